// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the multi-cycle data-memory pipeline stage:
//   - access size encodings
//   - FSM state type
//   - byte-enable generation for stores
//   - lane selection and sign/zero extension for loads
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Little-endian byte lanes touched by an access of the given size at the
  // given byte offset within the word. An illegal size touches nothing.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Pick the addressed byte/halfword out of a RAM word and widen it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        sign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{sign & b[7]}}, b};
      SZ_HALF: res = {{16{sign & h[15]}}, h};
      SZ_WORD: res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_mc_bank.sv
// -----------------------------------------------------------------------------
// data_mem_bank
// DEPTH x 32-bit data RAM with per-byte synchronous write enables and an
// asynchronous (combinational) word read.
// Ports:
//   clk    in   clock
//   be     in   4  byte write enables, bit i writes bits [8i+7:8i]
//   index  in   AW word index
//   wdata  in   32 write data, already positioned in its byte lanes
//   rdata  out  32 word at index
// -----------------------------------------------------------------------------
module data_mem_bank #(
  parameter int unsigned DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset; clearing every word would turn the array into
  // flops and prevent RAM inference. Contents after power-up are undefined.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/mem_stage_mc.sv
// -----------------------------------------------------------------------------
// mem_stage_mc
// Pipeline MEM stage with a configurable-latency data RAM. Decodes the
// effective address, holds the pipeline via stall while an access is in
// flight, and registers the result into the MEM/WB register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wb_en_in            write-back enable from EXE
//   mem_r_en_in         load request
//   mem_w_en_in         store request
//   size_in   [1:0]     0 byte, 1 half, 2 word, 3 illegal
//   sign_in             sign-extend loads when 1
//   dest_in   [4:0]     destination register
//   alu_result_in[31:0] effective byte address / ALU result
//   store_data_in[31:0] store data (low bytes for sub-word stores)
//   stall               combinational; upstream holds inputs while high
//   wb_en_out, mem_r_en_out, dest_out, alu_result_out, mem_data_out
//                       MEM/WB register outputs
//   addr_err            one-cycle pulse on a completed illegal access
// -----------------------------------------------------------------------------
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [1:0]  size_in,
  input  logic        sign_in,
  input  logic [4:0]  dest_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  output logic        stall,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [4:0]  dest_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH);
  // A zero-latency build still needs a legal (unused) one-bit counter.
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          access;
  logic [31:0]   offset;
  logic [1:0]    lane;
  logic [AW-1:0] index;
  logic          range_bad;
  logic          align_bad;
  logic          err;

  assign access = mem_r_en_in | mem_w_en_in;
  assign offset = alu_result_in - 32'(BASE_ADDR);
  // BASE_ADDR is word aligned, so the lane bits are the same in address and offset.
  assign lane   = alu_result_in[1:0];
  assign index  = offset[AW+1:2];

  assign range_bad = (alu_result_in < 32'(BASE_ADDR)) || (offset >= 32'(DEPTH * 4));
  assign align_bad = ((size_in == SZ_HALF) && alu_result_in[0]) ||
                     ((size_in == SZ_WORD) && (alu_result_in[1:0] != 2'b00));

  // Non-memory instructions never raise an address error.
  assign err = access & (range_bad | align_bad | (size_in == 2'd3) |
                         (mem_r_en_in & mem_w_en_in));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The IDLE cycle plus LATENCY BUSY cycles gives LATENCY+1 cycles per access;
  // the BUSY cycle that counts down to zero is the completing one.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned and infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && (LATENCY > 0)) begin
          stall   = 1'b1;
          cnt_d   = CW'(LATENCY);
          state_d = BUSY;
        end else begin
          complete = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q > CW'(1)) begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;

  // Replicate store data across lanes; the byte enables pick the right copy.
  always_comb begin
    wdata = store_data_in;
    case (size_in)
      SZ_BYTE: wdata = {4{store_data_in[7:0]}};
      SZ_HALF: wdata = {2{store_data_in[15:0]}};
      default: wdata = store_data_in;
    endcase
  end

  // A reset arriving on the completing edge drops the store.
  assign be = byte_enables(size_in, lane) &
              {4{complete & mem_w_en_in & ~err & ~rst}};

  data_mem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (clk),
    .be    (be),
    .index (index),
    .wdata (wdata),
    .rdata (rdata)
  );

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      dest_out       <= '0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      addr_err       <= 1'b0;
    end else if (complete) begin
      wb_en_out      <= wb_en_in & ~err;
      mem_r_en_out   <= mem_r_en_in;
      dest_out       <= dest_in;
      alu_result_out <= alu_result_in;
      mem_data_out   <= (mem_r_en_in && !err) ?
                        extend_load(rdata, size_in, lane, sign_in) : 32'h0;
      addr_err       <= err;
    end else begin
      // Bubble while the access is in flight; data fields simply hold.
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      addr_err     <= 1'b0;
    end
  end

endmodule
